// File: rtl/wb_board_pkg.sv
// Shared widths and FSM encoding for the board-memory Wishbone arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_board_pkg;

    localparam int ADDR_W = 8;   // 16x16 board -> 256 cells
    localparam int DATA_W = 16;
    localparam int OUT_W  = 4;   // outstanding-transfer counter width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_board_arbiter_picker.sv
// Round-robin picker: first requester after `last`, wrapping modulo N_M.
// Latency: purely combinational.
// Backpressure: none; the winner is only a suggestion until the top registers it.
//
// Ports: req (request vector), last (previous winner index),
//        gnt (one-hot winner), idx (winner index), vld (any request present).
module wb_rr_picker #(
    parameter int N_M   = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_M-1:0]   req,
    input  logic [IDX_W-1:0] last,
    output logic [N_M-1:0]   gnt,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    logic [IDX_W-1:0] cand;

    // Scan last+1 .. last+N_M; the final candidate is `last` itself, so a lone
    // requester that just finished still wins when nobody else is waiting.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        vld  = 1'b0;
        cand = '0;
        for (int i = 1; i <= N_M; i++) begin
            cand = IDX_W'((int'(last) + i) % N_M);
            if (!vld && req[cand]) begin
                vld       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/wb_board_arbiter.sv
// Round-robin arbiter sharing the board-memory Wishbone slave among N_M masters.
// Latency: grant 1 cycle after cyc request; strobe/stall/ack/data paths add 0 cycles.
// Backpressure: owner sees slave stall OR full outstanding window; non-owners always stalled.
//
// Ports: CLK_I/RST_I (sync, active-low); m_* per-master Wishbone buses (packed,
//        master k in slice k); s_* single slave port; grant_o one-hot owner.
module wb_board_arbiter
    import wb_board_pkg::*;
#(
    parameter int N_M     = 3,
    parameter int TIMEOUT = 64,
    parameter int MAX_OUT = 15
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic [N_M-1:0]        m_cyc_i,
    input  logic [N_M-1:0]        m_stb_i,
    input  logic [N_M-1:0]        m_we_i,
    input  logic [N_M*ADDR_W-1:0] m_adr_i,
    input  logic [N_M*DATA_W-1:0] m_dat_i,
    output logic [DATA_W-1:0]     m_dat_o,
    output logic [N_M-1:0]        m_ack_o,
    output logic [N_M-1:0]        m_stall_o,
    output logic [N_M-1:0]        m_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_W-1:0]     s_adr_o,
    output logic [DATA_W-1:0]     s_dat_o,
    input  logic [DATA_W-1:0]     s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_stall_i,
    output logic [N_M-1:0]        grant_o
);

    localparam int IDX_W = $clog2(N_M);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    arb_state_t       state_q, state_d;
    logic [N_M-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0] own_q,   own_d;
    logic [IDX_W-1:0] last_q,  last_d;
    logic [OUT_W-1:0] outst_q, outst_d;
    logic [WD_W-1:0]  wd_q,    wd_d;

    logic [N_M-1:0]   pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;

    logic full;
    logic owner_cyc;
    logic timeout;
    logic accept;
    logic ack_cnt;

    wb_rr_picker #(
        .N_M   (N_M),
        .IDX_W (IDX_W)
    ) u_picker (
        .req  (m_cyc_i),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .vld  (pick_vld)
    );

    // Read data is broadcast; only the owner's ack qualifies it.
    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_q <= IDLE;
            grant_q <= '0;
            own_q   <= '0;
            last_q  <= IDX_W'(N_M - 1);   // master 0 wins the first arbitration
            outst_q <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            own_q   <= own_d;
            last_q  <= last_d;
            outst_q <= outst_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        own_d     = own_q;
        last_d    = last_q;
        outst_d   = outst_q;
        wd_d      = wd_q;

        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        m_ack_o   = '0;
        m_stall_o = '1;
        m_err_o   = '0;

        full      = (outst_q == OUT_W'(MAX_OUT));
        owner_cyc = m_cyc_i[own_q];
        timeout   = (wd_q == WD_W'(TIMEOUT));
        accept    = 1'b0;
        ack_cnt   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = BUSY;
                    grant_d = pick_gnt;
                    own_d   = pick_idx;
                    last_d  = pick_idx;
                    outst_d = '0;
                    wd_d    = '0;
                end
            end

            BUSY: begin
                if (timeout) begin
                    // Abort cycle: bus released immediately, owner told once.
                    m_err_o[own_q] = 1'b1;
                    state_d        = ABORT;
                    outst_d        = '0;
                    wd_d           = '0;
                end else begin
                    s_cyc_o          = 1'b1;
                    s_stb_o          = m_stb_i[own_q] & owner_cyc & ~full;
                    s_we_o           = m_we_i[own_q];
                    s_adr_o          = m_adr_i[int'(own_q)*ADDR_W +: ADDR_W];
                    s_dat_o          = m_dat_i[int'(own_q)*DATA_W +: DATA_W];
                    m_stall_o[own_q] = s_stall_i | full;
                    // Forwarded even in the cycle the owner drops cyc.
                    m_ack_o[own_q]   = s_ack_i;

                    accept  = s_stb_o & ~s_stall_i;
                    ack_cnt = s_ack_i & (outst_q != '0);

                    if (!owner_cyc) begin
                        state_d = IDLE;
                        grant_d = '0;
                        outst_d = '0;
                        wd_d    = '0;
                    end else begin
                        if (accept && !ack_cnt) begin
                            outst_d = outst_q + 1'b1;
                        end else if (!accept && ack_cnt) begin
                            outst_d = outst_q - 1'b1;
                        end

                        // Watchdog only runs while the slave owes us something.
                        if (s_ack_i || (outst_q == '0)) begin
                            wd_d = '0;
                        end else begin
                            wd_d = wd_q + 1'b1;
                        end
                    end
                end
            end

            ABORT: begin
                // Slave-side acks are swallowed; wait for the owner to give up.
                if (!owner_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_board_arbiter.sv
module tb_wb_board_arbiter;

    logic        CLK_I;
    logic        RST_I;
    logic [2:0]  m_cyc_i, m_stb_i, m_we_i;
    logic [23:0] m_adr_i;
    logic [47:0] m_dat_i;
    logic [15:0] m_dat_o;
    logic [2:0]  m_ack_o, m_stall_o, m_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [7:0]  s_adr_o;
    logic [15:0] s_dat_o;
    logic [15:0] s_dat_i;
    logic        s_ack_i, s_stall_i;
    logic [2:0]  grant_o;

    wb_board_arbiter #(.N_M(3), .TIMEOUT(64), .MAX_OUT(15)) dut (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_stall_o (m_stall_o),
        .m_err_o   (m_err_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .s_stall_i (s_stall_i),
        .grant_o   (grant_o)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    typedef struct {
        logic        rst_n;
        logic [2:0]  cyc, stb, we;
        logic        ack, stall;
        logic [2:0]  grant;
        logic        scyc, sstb, swe;
        logic [7:0]  sadr;
        logic [15:0] sdo;
        logic [2:0]  mack, mstall, merr;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add_idle(input logic r, input logic [2:0] cyc, input logic [2:0] stb,
                            input logic [2:0] we, input logic ack, input logic stall);
        vec_t v;
        v.rst_n = r; v.cyc = cyc; v.stb = stb; v.we = we; v.ack = ack; v.stall = stall;
        v.grant = 3'b000; v.scyc = 1'b0; v.sstb = 1'b0; v.swe = 1'b0;
        v.sadr = 8'h00; v.sdo = 16'h0000;
        v.mack = 3'b000; v.mstall = 3'b111; v.merr = 3'b000;
        tbl.push_back(v);
    endtask

    task automatic add_busy(input logic [2:0] cyc, input logic [2:0] stb, input logic [2:0] we,
                            input logic ack, input logic stall, input logic [2:0] grant,
                            input logic sstb, input logic swe, input logic [7:0] sadr,
                            input logic [15:0] sdo, input logic [2:0] mack,
                            input logic [2:0] mstall);
        vec_t v;
        v.rst_n = 1'b1; v.cyc = cyc; v.stb = stb; v.we = we; v.ack = ack; v.stall = stall;
        v.grant = grant; v.scyc = 1'b1; v.sstb = sstb; v.swe = swe;
        v.sadr = sadr; v.sdo = sdo;
        v.mack = mack; v.mstall = mstall; v.merr = 3'b000;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    initial begin : main
        int first_err;
        int n_err;
        logic [2:0] err_val;
        logic abort_bus;

        RST_I     = 1'b0;
        m_cyc_i   = '0; m_stb_i = '0; m_we_i = '0;
        m_adr_i   = {8'h30, 8'h2A, 8'h10};
        m_dat_i   = {16'h3333, 16'h2222, 16'h1111};
        s_dat_i   = 16'h00F3;
        s_ack_i   = 1'b0;
        s_stall_i = 1'b0;
        step();
        step();

        // Reset state, then m1 single read at 0x2A acked two cycles after its strobe.
        add_idle(0, 3'b000, 3'b000, 3'b000, 0, 0);
        add_idle(1, 3'b010, 3'b010, 3'b000, 0, 0);
        add_busy(3'b010, 3'b010, 3'b000, 0, 0, 3'b010, 1, 0, 8'h2A, 16'h2222, 3'b000, 3'b101);
        add_busy(3'b010, 3'b000, 3'b000, 0, 0, 3'b010, 0, 0, 8'h2A, 16'h2222, 3'b000, 3'b101);
        add_busy(3'b010, 3'b000, 3'b000, 1, 0, 3'b010, 0, 0, 8'h2A, 16'h2222, 3'b010, 3'b101);
        add_busy(3'b000, 3'b000, 3'b000, 0, 0, 3'b010, 0, 0, 8'h2A, 16'h2222, 3'b000, 3'b101);
        add_idle(1, 3'b000, 3'b000, 3'b000, 0, 0);
        // Reset, then all three request continuously: order 0,1,2,0 with an idle gap each time.
        add_idle(0, 3'b000, 3'b000, 3'b000, 0, 0);
        add_idle(1, 3'b111, 3'b111, 3'b000, 0, 0);
        add_busy(3'b111, 3'b111, 3'b000, 0, 0, 3'b001, 1, 0, 8'h10, 16'h1111, 3'b000, 3'b110);
        add_busy(3'b110, 3'b110, 3'b000, 1, 0, 3'b001, 0, 0, 8'h10, 16'h1111, 3'b001, 3'b110);
        add_idle(1, 3'b111, 3'b111, 3'b000, 0, 0);
        add_busy(3'b111, 3'b111, 3'b000, 0, 0, 3'b010, 1, 0, 8'h2A, 16'h2222, 3'b000, 3'b101);
        add_busy(3'b101, 3'b101, 3'b000, 1, 0, 3'b010, 0, 0, 8'h2A, 16'h2222, 3'b010, 3'b101);
        add_idle(1, 3'b111, 3'b111, 3'b000, 0, 0);
        add_busy(3'b111, 3'b111, 3'b000, 0, 0, 3'b100, 1, 0, 8'h30, 16'h3333, 3'b000, 3'b011);
        add_busy(3'b011, 3'b011, 3'b000, 1, 0, 3'b100, 0, 0, 8'h30, 16'h3333, 3'b100, 3'b011);
        add_idle(1, 3'b111, 3'b111, 3'b000, 0, 0);
        add_busy(3'b111, 3'b111, 3'b000, 0, 0, 3'b001, 1, 0, 8'h10, 16'h1111, 3'b000, 3'b110);
        add_busy(3'b000, 3'b000, 3'b000, 1, 0, 3'b001, 0, 0, 8'h10, 16'h1111, 3'b001, 3'b110);
        add_idle(1, 3'b000, 3'b000, 3'b000, 0, 0);
        // m2 burst of 4 writes, slave stalls 3 cycles; 4 accepted, 4 acks routed.
        add_idle(1, 3'b100, 3'b100, 3'b100, 0, 0);
        add_busy(3'b100, 3'b100, 3'b100, 0, 0, 3'b100, 1, 1, 8'h30, 16'h3333, 3'b000, 3'b011);
        add_busy(3'b100, 3'b100, 3'b100, 0, 1, 3'b100, 1, 1, 8'h30, 16'h3333, 3'b000, 3'b111);
        add_busy(3'b100, 3'b100, 3'b100, 1, 1, 3'b100, 1, 1, 8'h30, 16'h3333, 3'b100, 3'b111);
        add_busy(3'b100, 3'b100, 3'b100, 0, 1, 3'b100, 1, 1, 8'h30, 16'h3333, 3'b000, 3'b111);
        add_busy(3'b100, 3'b100, 3'b100, 0, 0, 3'b100, 1, 1, 8'h30, 16'h3333, 3'b000, 3'b011);
        add_busy(3'b100, 3'b100, 3'b100, 1, 0, 3'b100, 1, 1, 8'h30, 16'h3333, 3'b100, 3'b011);
        add_busy(3'b100, 3'b100, 3'b100, 1, 0, 3'b100, 1, 1, 8'h30, 16'h3333, 3'b100, 3'b011);
        add_busy(3'b100, 3'b000, 3'b100, 1, 0, 3'b100, 0, 1, 8'h30, 16'h3333, 3'b100, 3'b011);
        add_busy(3'b000, 3'b000, 3'b000, 0, 0, 3'b100, 0, 0, 8'h30, 16'h3333, 3'b000, 3'b011);
        add_idle(1, 3'b000, 3'b000, 3'b000, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            RST_I     = tbl[i].rst_n;
            m_cyc_i   = tbl[i].cyc;
            m_stb_i   = tbl[i].stb;
            m_we_i    = tbl[i].we;
            s_ack_i   = tbl[i].ack;
            s_stall_i = tbl[i].stall;
            #1;
            n_vec++;
            if (grant_o !== tbl[i].grant || s_cyc_o !== tbl[i].scyc || s_stb_o !== tbl[i].sstb ||
                s_we_o !== tbl[i].swe || s_adr_o !== tbl[i].sadr || s_dat_o !== tbl[i].sdo ||
                m_ack_o !== tbl[i].mack || m_stall_o !== tbl[i].mstall ||
                m_err_o !== tbl[i].merr || m_dat_o !== 16'h00F3) begin
                n_bad++;
                $display("FAIL vec%0d: got gnt=%b cyc=%b stb=%b we=%b adr=%h sdo=%h ack=%b stall=%b err=%b mdat=%h; expected gnt=%b cyc=%b stb=%b we=%b adr=%h sdo=%h ack=%b stall=%b err=000 mdat=00f3",
                         i, grant_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m_ack_o,
                         m_stall_o, m_err_o, m_dat_o, tbl[i].grant, tbl[i].scyc, tbl[i].sstb,
                         tbl[i].swe, tbl[i].sadr, tbl[i].sdo, tbl[i].mack, tbl[i].mstall);
            end
            step();
        end

        // Watchdog: m0 issues 15 un-acked strobes, 16th stalls, err after 64 ack-less cycles.
        RST_I = 1'b1; m_we_i = 3'b000; s_ack_i = 1'b0; s_stall_i = 1'b0;
        m_cyc_i = 3'b001; m_stb_i = 3'b001;
        step();                                     // grant cycle c=0 begins
        for (int c = 0; c < 15; c++) begin
            #1;
            chk($sformatf("to_accept_c%0d", c), {30'd0, s_stb_o, m_stall_o[0]}, 32'd2);
            step();
        end
        first_err = -1; n_err = 0; err_val = '0; abort_bus = 1'b0;
        for (int c = 15; c < 130; c++) begin
            #1;
            if (c == 15)
                chk("to_full_stall", {30'd0, s_stb_o, m_stall_o[0]}, 32'd1);
            if (m_err_o != 3'b000) begin
                n_err++;
                if (first_err < 0) begin
                    first_err = c;
                    err_val   = m_err_o;
                end
            end
            if (c > 65 && (s_cyc_o || s_stb_o || m_stall_o != 3'b111 || m_ack_o != 3'b000))
                abort_bus = 1'b1;
            step();
        end
        chk("to_err_cycle", first_err, 65);
        chk("to_err_count", n_err, 1);
        chk("to_err_owner", {29'd0, err_val}, 32'd1);
        chk("to_abort_bus_quiet", {31'd0, abort_bus}, 32'd0);
        #1;
        chk("to_abort_grant", {29'd0, grant_o}, 32'd1);
        m_cyc_i = 3'b000; m_stb_i = 3'b000;
        step();
        #1;
        chk("to_release_grant", {29'd0, grant_o}, 32'd0);

        // Reset while m1 owns the bus with 3 outstanding.
        m_cyc_i = 3'b010; m_stb_i = 3'b010;
        step();
        for (int c = 0; c < 3; c++) step();
        #1;
        chk("rst_pre_grant", {29'd0, grant_o}, 32'd2);
        RST_I = 1'b0;
        step();
        #1;
        chk("rst_grant", {29'd0, grant_o}, 32'd0);
        chk("rst_scyc", {31'd0, s_cyc_o}, 32'd0);
        chk("rst_stall", {29'd0, m_stall_o}, 32'd7);
        RST_I = 1'b1; m_cyc_i = 3'b111; m_stb_i = 3'b111; s_ack_i = 1'b1;
        #1;
        chk("rst_late_ack", {29'd0, m_ack_o}, 32'd0);
        step();
        s_ack_i = 1'b0;
        #1;
        chk("rst_next_winner", {29'd0, grant_o}, 32'd1);
        chk("rst_next_adr", {24'd0, s_adr_o}, 32'h10);
        m_cyc_i = 3'b000; m_stb_i = 3'b000;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
